string_editor: RTL

STRING_EDITOR -- requirements
Module: string_editor

---
 rtl/string_editor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/string_editor.sv
// Line editor: fixed-depth character buffer with insert/overwrite, backspace, cursor moves and a commit stream.
// Latency: edits and flags update one cycle after the strobe; commit data appears the cycle after the commit strobe.
// Backpressure: the commit stream holds o_out_valid/o_out_data stable until i_out_ready; edits during streaming are rejected.
module string_editor #(
  parameter int  DEPTH  = 8,
  parameter int  CHAR_W = 8,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_sclr,
  input  logic              i_char_en,
  input  logic [CHAR_W-1:0] i_char,
  input  logic              i_bs_en,
  input  logic              i_left_en,
  input  logic              i_right_en,
  input  logic              i_commit_en,
  input  logic              i_ins_mode,
  input  logic [LW-1:0]     i_rd_idx,
  output logic [CHAR_W-1:0] o_rd_data,
  output logic [LW-1:0]     o_len,
  output logic [LW-1:0]     o_cursor,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_busy,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CHAR_W-1:0] o_out_data,
  output logic              o_done,
  output logic              o_rej
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q;
  logic [CHAR_W-1:0] buf_q [DEPTH];
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     cursor_q;
  logic [LW-1:0]     idx_q;
  logic              out_valid_q;
  logic [CHAR_W-1:0] out_data_q;
  logic              done_q;
  logic              rej_q;

  logic              any_strobe;
  logic              is_full;
  logic              do_insert;
  logic              last_beat;
  logic [CHAR_W-1:0] next_data;
  logic [CHAR_W-1:0] rd_data;

  assign any_strobe = i_char_en | i_bs_en | i_left_en | i_right_en | i_commit_en;
  assign is_full    = (len_q == LW'(DEPTH));
  // Overwrite at the end of the string has nothing to replace, so it extends like an insert.
  assign do_insert  = i_ins_mode || (cursor_q == len_q);
  assign last_beat  = (idx_q == len_q - LW'(1));

  // Character following the one currently presented on the stream.
  always_comb begin
    next_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == int'(idx_q) + 1) next_data = buf_q[k];
    end
  end

  // Display read port; out-of-range indices fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(i_rd_idx) == k) rd_data = buf_q[k];
    end
  end

  // Edit/stream state machine; slots at or beyond len are kept at zero by every operation.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      for (int k = 0; k < DEPTH; k++) buf_q[k] <= '0;
      len_q       <= '0;
      cursor_q    <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rej_q  <= 1'b0;
      if (i_sclr) begin
        state_q     <= IDLE;
        for (int k = 0; k < DEPTH; k++) buf_q[k] <= '0;
        len_q       <= '0;
        cursor_q    <= '0;
        idx_q       <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else if (state_q == STREAM) begin
        if (any_strobe) rej_q <= 1'b1;
        if (out_valid_q && i_out_ready) begin
          if (last_beat) begin
            state_q     <= IDLE;
            for (int k = 0; k < DEPTH; k++) buf_q[k] <= '0;
            len_q       <= '0;
            cursor_q    <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b1;
          end else begin
            idx_q      <= idx_q + LW'(1);
            out_data_q <= next_data;
          end
        end
      end else begin
        if (i_commit_en) begin
          if (len_q == '0) begin
            rej_q <= 1'b1;
          end else begin
            state_q     <= STREAM;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= buf_q[0];
          end
        end else if (i_bs_en) begin
          if (cursor_q == '0) begin
            rej_q <= 1'b1;
          end else begin
            // Close the gap left by the deleted character; the top slot always becomes free.
            for (int k = 0; k < DEPTH - 1; k++) begin
              if (k >= int'(cursor_q) - 1) buf_q[k] <= buf_q[k+1];
            end
            buf_q[DEPTH-1] <= '0;
            len_q    <= len_q - LW'(1);
            cursor_q <= cursor_q - LW'(1);
          end
        end else if (i_char_en) begin
          if (do_insert) begin
            if (is_full) begin
              rej_q <= 1'b1;
            end else begin
              // Open a hole at the cursor, then drop the new character into it.
              for (int k = 1; k < DEPTH; k++) begin
                if (k > int'(cursor_q)) buf_q[k] <= buf_q[k-1];
              end
              for (int k = 0; k < DEPTH; k++) begin
                if (k == int'(cursor_q)) buf_q[k] <= i_char;
              end
              len_q    <= len_q + LW'(1);
              cursor_q <= cursor_q + LW'(1);
            end
          end else begin
            for (int k = 0; k < DEPTH; k++) begin
              if (k == int'(cursor_q)) buf_q[k] <= i_char;
            end
            cursor_q <= cursor_q + LW'(1);
          end
        end else if (i_left_en) begin
          if (cursor_q == '0) rej_q <= 1'b1;
          else                cursor_q <= cursor_q - LW'(1);
        end else if (i_right_en) begin
          if (cursor_q == len_q) rej_q <= 1'b1;
          else                   cursor_q <= cursor_q + LW'(1);
        end
      end
    end
  end

  assign o_rd_data   = rd_data;
  assign o_len       = len_q;
  assign o_cursor    = cursor_q;
  assign o_full      = is_full;
  assign o_empty     = (len_q == '0);
  assign o_busy      = (state_q == STREAM);
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_done      = done_q;
  assign o_rej       = rej_q;

endmodule
